// File: rtl/vga_ram_pkg.sv
// Shared definitions for the VGA RAM line packer: line geometry, packer states
// and the byte-lane offset helper.
package vga_ram_pkg;

    localparam int LINE_BYTES = 128;
    localparam int LINE_W     = 8 * LINE_BYTES;
    localparam int BYTE_IDX_W = 8;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_t;

    function automatic int unsigned lane_off(input int unsigned idx);
        return idx * 8;
    endfunction

endpackage

// File: rtl/vga_ram_line_reg.sv
// 1024-bit line register built from byte lanes: single-byte write by index,
// whole-line parallel load, and synchronous clear (clear wins over load/write).
module vga_ram_line_reg
    import vga_ram_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [BYTE_IDX_W-1:0] wr_idx,
    input  logic [7:0]            wr_byte,
    input  logic                  load,
    input  logic [LINE_W-1:0]     load_data,
    output logic [LINE_W-1:0]     q
);

    for (genvar k = 0; k < LINE_BYTES; k++) begin : g_lane
        logic [7:0] lane;
        logic       hit;

        assign hit = wr_en && (wr_idx == BYTE_IDX_W'(k));

        always_ff @(posedge clk) begin
            if (rst || clear) begin
                lane <= '0;
            end else if (load) begin
                lane <= load_data[lane_off(k) +: 8];
            end else if (hit) begin
                lane <= wr_byte;
            end
        end

        assign q[lane_off(k) +: 8] = lane;
    end

endmodule

// File: rtl/vga_ram_line_packer.sv
// Packs a byte stream into 128-byte lines for the VGA RAM line write port.
// Define VGA_PACK_DBUF_EN for a separate output register (no fill bubble).
module vga_ram_line_packer
    import vga_ram_pkg::*;
#(
    parameter int BYTES_PER_LINE = LINE_BYTES,
    parameter int IDX_W          = BYTE_IDX_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  in_byte,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        flush,
    output logic [8*BYTES_PER_LINE-1:0] line_data,
    output logic [IDX_W-1:0]            line_len,
    output logic                        line_valid,
    input  logic                        line_ready,
    output logic [IDX_W-1:0]            wr_idx
);

    pack_state_t                 state;
    pack_state_t                 state_nxt;
    logic                        accept;
    logic                        transfer;
    logic                        last_slot;
    logic                        complete;
    logic                        fill_clear;
    logic [IDX_W-1:0]            len_nxt;
    logic [8*BYTES_PER_LINE-1:0] fill_q;

    assign accept    = in_valid && in_ready;
    assign transfer  = line_valid && line_ready;
    assign last_slot = (wr_idx == IDX_W'(BYTES_PER_LINE - 1));

    // A line closes on its last slot, or on a flush that has at least one byte (this cycle's counts).
    assign complete = (state == FILL) &&
                      ((accept && last_slot) || (flush && (accept || (wr_idx != '0))));
    assign len_nxt  = (accept && last_slot) ? '0 : wr_idx + IDX_W'(accept);

    vga_ram_line_reg u_fill (
        .clk       (clk),
        .rst       (rst),
        .clear     (fill_clear),
        .wr_en     (accept),
        .wr_idx    (wr_idx),
        .wr_byte   (in_byte),
        .load      (1'b0),
        .load_data ('0),
        .q         (fill_q)
    );

`ifdef VGA_PACK_DBUF_EN
    logic                        out_valid;
    logic                        out_free;
    logic                        out_load;
    logic [IDX_W-1:0]            pend_len;
    logic [8*BYTES_PER_LINE-1:0] merged;
    logic [8*BYTES_PER_LINE-1:0] out_src;
    logic [8*BYTES_PER_LINE-1:0] out_q;

    assign out_free   = !out_valid || line_ready;
    assign out_load   = (complete && out_free) || ((state == HOLD) && transfer);
    assign fill_clear = out_load;
    assign line_data  = out_q;

    // The completing byte is not yet in the fill register, so merge it on the way out.
    always_comb begin
        merged = fill_q;
        if (accept) begin
            merged[lane_off(32'(wr_idx)) +: 8] = in_byte;
        end
        out_src = (state == HOLD) ? fill_q : merged;
    end

    vga_ram_line_reg u_out (
        .clk       (clk),
        .rst       (rst),
        .clear     (1'b0),
        .wr_en     (1'b0),
        .wr_idx    ('0),
        .wr_byte   (8'h00),
        .load      (out_load),
        .load_data (out_src),
        .q         (out_q)
    );

    always_comb begin
        state_nxt  = state;
        in_ready   = (state == FILL);
        line_valid = out_valid;
        case (state)
            FILL:    if (complete && !out_free) state_nxt = HOLD;
            HOLD:    if (transfer) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            wr_idx    <= '0;
            line_len  <= '0;
            pend_len  <= '0;
            out_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (complete) begin
                wr_idx <= '0;
            end else if (accept) begin
                wr_idx <= wr_idx + 1'b1;
            end
            if (complete && !out_free) begin
                pend_len <= len_nxt;
            end
            if (out_load) begin
                line_len  <= (state == HOLD) ? pend_len : len_nxt;
                out_valid <= 1'b1;
            end else if (transfer) begin
                out_valid <= 1'b0;
            end
        end
    end
`else
    assign fill_clear = (state == HOLD) && transfer;
    assign line_data  = fill_q;

    always_comb begin
        state_nxt  = state;
        in_ready   = (state == FILL);
        line_valid = (state == HOLD);
        case (state)
            FILL:    if (complete) state_nxt = HOLD;
            HOLD:    if (transfer) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FILL;
            wr_idx   <= '0;
            line_len <= '0;
        end else begin
            state <= state_nxt;
            if (complete) begin
                wr_idx   <= '0;
                line_len <= len_nxt;
            end else if (accept) begin
                wr_idx <= wr_idx + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_ram_line_packer.sv
// Randomized self-checking bench for vga_ram_line_packer against a line-level
// queue model; follows VGA_PACK_DBUF_EN to pick the expected buffering.
module tb_vga_ram_line_packer;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    in_byte;
    logic          in_valid;
    logic          in_ready;
    logic          flush;
    logic [1023:0] line_data;
    logic [7:0]    line_len;
    logic          line_valid;
    logic          line_ready;
    logic [7:0]    wr_idx;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: bytes of the line being filled, the presented line, and
    // (double-buffered build only) a completed line waiting for the output.
    logic [7:0]    cur[$];
    bit            m_out;
    logic [1023:0] m_out_line;
    logic [7:0]    m_out_len;
    bit            m_pend;
    logic [1023:0] m_pend_line;
    logic [7:0]    m_pend_len;
    bit            last_acc;
    logic [7:0]    src[$];

    always #5 clk = ~clk;

    vga_ram_line_packer dut (
        .clk        (clk),
        .rst        (rst),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .line_data  (line_data),
        .line_len   (line_len),
        .line_valid (line_valid),
        .line_ready (line_ready),
        .wr_idx     (wr_idx)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic bit modelReady();
`ifdef VGA_PACK_DBUF_EN
        return !m_pend;
`else
        return !m_out;
`endif
    endfunction

    task automatic modelReset();
        cur.delete();
        m_out      = 1'b0;
        m_out_line = '0;
        m_out_len  = '0;
        m_pend     = 1'b0;
        m_pend_line = '0;
        m_pend_len = '0;
        last_acc   = 1'b0;
    endtask

    task automatic modelStep(input bit v, input logic [7:0] b, input bit f, input bit r);
        bit            rdy;
        bit            xfer;
        bit            formed;
        logic [1023:0] nl;
        logic [7:0]    nlen;
        rdy      = modelReady();
        xfer     = m_out && r;
        last_acc = v && rdy;
        formed   = 1'b0;
        nl       = '0;
        nlen     = '0;
        if (last_acc) cur.push_back(b);
        if (rdy && (cur.size() == 128 || (f && cur.size() > 0))) begin
            for (int i = 0; i < cur.size(); i++) nl[8*i +: 8] = cur[i];
            nlen   = (cur.size() == 128) ? 8'd0 : 8'(cur.size());
            formed = 1'b1;
            cur.delete();
        end
`ifdef VGA_PACK_DBUF_EN
        if (formed) begin
            if (!m_out || xfer) begin
                m_out = 1'b1; m_out_line = nl; m_out_len = nlen;
            end else begin
                m_pend = 1'b1; m_pend_line = nl; m_pend_len = nlen;
            end
        end else if (xfer) begin
            if (m_pend) begin
                m_out_line = m_pend_line; m_out_len = m_pend_len; m_pend = 1'b0;
            end else begin
                m_out = 1'b0;
            end
        end
`else
        if (xfer) m_out = 1'b0;
        if (formed) begin
            m_out = 1'b1; m_out_line = nl; m_out_len = nlen;
        end
`endif
    endtask

    // Called just after a rising edge: drive, check at the falling edge, advance the model.
    task automatic applyStimulus(input bit v, input logic [7:0] b, input bit f, input bit r, input bit rs);
        in_valid   = v;
        in_byte    = b;
        flush      = f;
        line_ready = r;
        rst        = rs;
        @(negedge clk);
        checkOutput("in_ready", 64'(in_ready), 64'(modelReady()));
        checkOutput("line_valid", 64'(line_valid), 64'(m_out));
        checkOutput("wr_idx", 64'(wr_idx), 64'(cur.size()));
        if (m_out) begin
            checkOutput("line_len", 64'(line_len), 64'(m_out_len));
            for (int i = 0; i < 16; i++)
                checkOutput($sformatf("line_data[%0d]", i), line_data[64*i +: 64], m_out_line[64*i +: 64]);
        end
        if (rs) modelReset();
        else    modelStep(v, b, f, r);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic pump(input int cycles, input int vp, input int fp, input int rp, input bit refill);
        for (int c = 0; c < cycles; c++) begin
            bit         v;
            bit         f;
            bit         r;
            logic [7:0] b;
            if (refill && src.size() == 0) src.push_back(8'($urandom));
            v = (src.size() > 0) && ($urandom_range(99) < vp);
            b = v ? src[0] : 8'($urandom);
            f = $urandom_range(99) < fp;
            r = $urandom_range(99) < rp;
            applyStimulus(v, b, f, r, 1'b0);
            if (last_acc) void'(src.pop_front());
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        checkOutput({tag, "_line_valid"}, 64'(line_valid), 64'd0);
        checkOutput({tag, "_wr_idx"}, 64'(wr_idx), 64'd0);
        checkOutput({tag, "_line_len"}, 64'(line_len), 64'd0);
        for (int i = 0; i < 16; i++)
            checkOutput({tag, "_data"}, line_data[64*i +: 64], 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        in_byte    = '0;
        in_valid   = 1'b0;
        flush      = 1'b0;
        line_ready = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkResetState("reset");

        $display("[TB] full line 0x00..0x7F");
        for (int k = 0; k < 128; k++) src.push_back(8'(k));
        pump(128, 100, 0, 100, 0);
        pump(4, 0, 0, 100, 0);

        $display("[TB] partial flush");
        src.push_back(8'hA5);
        src.push_back(8'h5A);
        pump(2, 100, 0, 100, 0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        pump(2, 0, 0, 0, 0);
        pump(3, 0, 0, 100, 0);

        $display("[TB] empty flush and flush with same-cycle byte");
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) src.push_back(8'(k));
        pump(3, 100, 0, 100, 0);
        applyStimulus(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        pump(3, 0, 0, 100, 0);

        $display("[TB] backpressure");
        for (int k = 0; k < 128; k++) src.push_back(8'(k) ^ 8'h3C);
        pump(128, 100, 0, 0, 0);
        pump(20, 0, 0, 0, 0);
        pump(4, 0, 0, 100, 0);

        $display("[TB] reset mid-line");
        for (int k = 0; k < 50; k++) src.push_back(8'($urandom));
        pump(50, 100, 0, 100, 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("midrst_wr_idx", 64'(wr_idx), 64'd0);
        checkOutput("midrst_line_valid", 64'(line_valid), 64'd0);
        src.delete();
        src.push_back(8'hC3);
        src.push_back(8'h3C);
        src.push_back(8'h99);
        pump(3, 100, 0, 100, 0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        pump(3, 0, 0, 100, 0);

        $display("[TB] sustained 256 bytes with line_ready high");
        for (int k = 0; k < 256; k++) src.push_back(8'($urandom));
        pump(300, 100, 0, 100, 0);

        $display("[TB] random traffic");
        pump(3000, 80, 3, 60, 1);
        src.delete();
        pump(200, 0, 0, 100, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_ram_line_packer.md
Name: vga_ram_line_packer

Overview:
- Writer side of the 1024-bit VGA RAM line bus: accepts a byte stream with a valid/ready handshake and packs it into one 128-byte line.
- Byte k lands in line[8k+7:8k], so a downstream byte selector at index k returns byte k unchanged.
- Completed or flushed lines are presented on line_data with a valid/ready handshake for the VGA RAM line write port.

Parameters:
- BYTES_PER_LINE, 128, bytes per line; line width is 8*BYTES_PER_LINE = 1024.
- IDX_W, 8, width of byte-index and length fields.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- in_byte  input  8  byte to pack.
- in_valid  input  1  in_byte is valid.
- in_ready  output  1  packer can accept a byte this cycle.
- flush  input  1  one-cycle request to close the current partial line.
- line_data  output  1024  packed line; byte k is at [8k+7:8k].
- line_len  output  IDX_W  valid bytes in line_data, 1..128; 128 encodes as 0 (wrap of the 8-bit field).
- line_valid  output  1  line_data/line_len are valid.
- line_ready  input  1  consumer accepts the line.
- wr_idx  output  IDX_W  next byte slot in the fill buffer, 0..127.

Behaviour:
- Accept: in_valid & in_ready. Transfer: line_valid & line_ready.
- Reset values:
  - in_ready=1, line_valid=0, wr_idx=0, line_len=0.
  - Fill buffer and line_data are cleared to all zero.
  - State is FILL.
- Reset is honoured mid-operation: any partial line and any pending line are discarded.
- States (no double buffer):
  - FILL: in_ready=1, line_valid=0. Each accept writes fill[8*wr_idx+:8]=in_byte and increments wr_idx.
  - FILL exits to HOLD on either of:
    - an accept at wr_idx=127; line_len=128 (encodes 0), wr_idx wraps to 0;
    - flush with wr_idx>0, or flush together with an accept; line_len = bytes written including a same-cycle byte.
  - HOLD: in_ready=0, line_valid=1, and line_data/line_len stay stable until transfer.
  - HOLD exits to FILL in the cycle after transfer. On that exit the fill buffer is zeroed and wr_idx=0.
- Latency: line_valid rises the cycle after the 128th accept or after the flush edge.
- Flush:
  - flush with wr_idx=0 and no accept is ignored; no empty line is emitted.
  - flush asserted in HOLD is ignored (not queued).
- Unwritten byte slots of a flushed line read as 0.
- in_valid while in_ready=0: no state change; the source holds the byte.
- line_ready while line_valid=0 has no effect.
- in_ready does not depend combinationally on in_valid. line_valid does not depend combinationally on line_ready.

Optional Feature:
- Macro: VGA_PACK_DBUF_EN.
- Defined:
  - Separate output register. On line completion, if the output is empty or transferring in the same cycle, the fill buffer moves to the output and FILL continues with no bubble. in_ready stays 1.
  - in_ready drops only when the fill buffer has just completed and the output still holds an unaccepted line. It returns the cycle after that line transfers.
  - Sustained 1 byte/cycle is possible when line_ready is held high.
- Undefined: single-buffer FILL/HOLD behaviour above. in_ready is low for at least 1 cycle per line.

Decomposition:
- Shared package vga_ram_pkg:
  - LINE_BYTES=128, LINE_W=1024, BYTE_IDX_W=8;
  - state enum FILL/HOLD;
  - byte-lane offset function (idx*8).
- One sub-module is natural: vga_ram_line_reg, the 1024-bit line register with per-byte write-enable decode and synchronous clear. It is instantiated once for fill and, under VGA_PACK_DBUF_EN, once for output.

Test Plan:
- Full line: send bytes 0x00..0x7F with line_ready=1 → line_valid rises 1 cycle after the last accept; line_data[8k+7:8k]=k for all k; line_len=0 (encodes 128).
- Partial flush: send 0xA5,0x5A, then pulse flush → line_len=2; bytes 0..1 = A5,5A; bytes 2..127 = 0.
- Flush with same-cycle byte: at wr_idx=3, accept 0x11 together with flush → line_len=4; byte 3 = 0x11.
- Backpressure: hold line_ready=0 for 20 cycles after a full line → line_data stable, in_ready=0 (non-DBUF). Raise line_ready → transfer, and in_ready=1 the next cycle.
- Reset mid-line: 50 bytes written, rst for 1 cycle → wr_idx=0, line_valid=0. The next line contains only post-reset bytes.
- DBUF (VGA_PACK_DBUF_EN): continuous in_valid for 256 bytes with line_ready=1 → in_ready never drops; two lines emitted 128 cycles apart.
